// File: rtl/jami_glitch_filter.sv
// Inertial-delay glitch filter: synchronises a_in, then only lets a new level through
// to y_out once it has been held for STABLE_CYCLES consecutive cycles.
module jami_glitch_filter #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int GCNT_W        = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_in,
   input  logic              glitch_clr,
   output logic              y_out,
   output logic              rise_pulse,
   output logic              fall_pulse,
   output logic              glitch_flag,
   output logic [GCNT_W-1:0] glitch_cnt
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   a_sync;
   logic [CW-1:0]          cnt;
   logic                   differ;
   logic                   qualified;
   logic                   glitch_event;
   logic [GCNT_W-1:0]      gcnt_next;

   assign a_sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= a_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // A glitch is a partial qualification that the synchronised input abandoned.
   always_comb begin
      differ       = (a_sync != y_out);
      qualified    = differ && (cnt == CNT_LAST);
      glitch_event = !differ && (cnt != '0);
      gcnt_next    = glitch_cnt;
      if (glitch_clr) begin
         gcnt_next = glitch_event ? GCNT_W'(1) : '0;
      end else if (glitch_event && (glitch_cnt != '1)) begin
         gcnt_next = glitch_cnt + GCNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_out       <= 1'b0;
         cnt         <= '0;
         rise_pulse  <= 1'b0;
         fall_pulse  <= 1'b0;
         glitch_flag <= 1'b0;
         glitch_cnt  <= '0;
      end else begin
         rise_pulse  <= qualified && a_sync;
         fall_pulse  <= qualified && !a_sync;
         glitch_flag <= glitch_event;
         glitch_cnt  <= gcnt_next;
         if (qualified) begin
            y_out <= a_sync;
            cnt   <= '0;
         end else if (differ) begin
            cnt <= cnt + CW'(1);
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_jami_glitch_filter.sv
// Directed and random stimulus for jami_glitch_filter, checked every cycle against a
// delay-line plus run-history model of the filtering rules.
module tb_jami_glitch_filter;

   localparam int S    = 2;
   localparam int N    = 4;
   localparam int GW   = 8;
   localparam int GMAX = (1 << GW) - 1;

   logic          clk;
   logic          rst;
   logic          a_in;
   logic          glitch_clr;
   logic          y_out;
   logic          rise_pulse;
   logic          fall_pulse;
   logic          glitch_flag;
   logic [GW-1:0] glitch_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic m_pipe[$];
   logic seg[$];
   logic my, mrise, mfall, mflag;
   int   mg;

   jami_glitch_filter #(
      .SYNC_STAGES  (S),
      .STABLE_CYCLES(N),
      .GCNT_W       (GW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .a_in       (a_in),
      .glitch_clr (glitch_clr),
      .y_out      (y_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .glitch_flag(glitch_flag),
      .glitch_cnt (glitch_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // y changes once the synchronised input has shown the other level for N edges in a row.
   task automatic model_edge(input logic a, input logic clr, input logic r);
      logic as;
      if (r) begin
         m_pipe = {};
         repeat (S) m_pipe.push_back(1'b0);
         seg = {};
         my = 0; mrise = 0; mfall = 0; mflag = 0; mg = 0;
      end else begin
         as = m_pipe[S-1];
         m_pipe.push_front(a);
         void'(m_pipe.pop_back());
         mrise = 0; mfall = 0; mflag = 0;
         if (as == my) begin
            mflag = (seg.size() > 0);
            seg.delete();
         end else begin
            seg.push_back(as);
            if (seg.size() == N) begin
               mrise = as;
               mfall = !as;
               my    = as;
               seg.delete();
            end
         end
         if (clr) mg = mflag ? 1 : 0;
         else if (mflag && mg < GMAX) mg++;
      end
   endtask

   task automatic step(input logic a, input logic clr, input logic r);
      a_in = a; glitch_clr = clr; rst = r;
      @(posedge clk);
      model_edge(a, clr, r);
      #1;
      check("y_out", y_out, my);
      check("rise_pulse", rise_pulse, mrise);
      check("fall_pulse", fall_pulse, mfall);
      check("glitch_flag", glitch_flag, mflag);
      check("glitch_cnt", glitch_cnt, mg);
   endtask

   initial begin
      int g0, flags, hi, rises, falls, rise_t, fall_t, t;
      int lvl, len;
      int pat_len[8] = '{4, 1, 4, 2, 1, 4, 4, 4};
      rst = 1'b1; a_in = 1'b0; glitch_clr = 1'b0;
      model_edge(1'b0, 1'b0, 1'b1);

      // reset with a_in high, then release
      repeat (3) step(1'b1, 1'b0, 1'b1);
      check("rst_y", y_out, 0);
      check("rst_gcnt", glitch_cnt, 0);
      check("rst_strobes", {rise_pulse, fall_pulse, glitch_flag}, 0);
      repeat (5) step(1'b1, 1'b0, 1'b0);
      check("release_y_before", y_out, 0);
      step(1'b1, 1'b0, 1'b0);
      check("release_y", y_out, 1);
      check("release_rise", rise_pulse, 1);
      step(1'b1, 1'b0, 1'b0);
      check("release_rise_once", rise_pulse, 0);
      repeat (10) step(1'b0, 1'b0, 1'b0);

      // short pulses are rejected
      g0 = mg; flags = 0;
      for (int p = 1; p <= 3; p++) begin
         repeat (p) begin step(1'b1, 1'b0, 1'b0); if (glitch_flag) flags++; end
         repeat (6) begin step(1'b0, 1'b0, 1'b0); if (glitch_flag) flags++; end
      end
      check("filter_flags", flags, 3);
      check("filter_gcnt", glitch_cnt, g0 + 3);
      check("filter_y", y_out, 0);

      // a 4-cycle pulse passes
      g0 = mg; hi = 0; rises = 0; falls = 0; rise_t = 0; fall_t = 0; t = 0;
      for (int i = 0; i < 12; i++) begin
         step((i < 4) ? 1'b1 : 1'b0, 1'b0, 1'b0);
         t++;
         if (y_out) hi++;
         if (rise_pulse) begin rises++; rise_t = t; end
         if (fall_pulse) begin falls++; fall_t = t; end
      end
      check("pass_high_cycles", hi, 4);
      check("pass_rises", rises, 1);
      check("pass_falls", falls, 1);
      check("pass_spacing", fall_t - rise_t, 4);
      check("pass_gcnt", glitch_cnt, g0);

      // alternating segment pattern
      for (int s = 0; s < 8; s++) begin
         repeat (pat_len[s]) step(s[0], 1'b0, 1'b0);
      end
      repeat (8) step(1'b0, 1'b0, 1'b0);

      // saturation, clear coinciding with a glitch, clear alone
      repeat (260) begin
         step(1'b1, 1'b0, 1'b0);
         repeat (3) step(1'b0, 1'b0, 1'b0);
      end
      check("sat_gcnt", glitch_cnt, GMAX);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      check("clr_with_glitch", glitch_cnt, 1);
      step(1'b0, 1'b1, 1'b0);
      check("clr_alone", glitch_cnt, 0);

      // reset while a rising level is part-way qualified
      repeat (8) step(1'b0, 1'b0, 1'b0);
      repeat (4) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      check("midrst_y", y_out, 0);
      repeat (5) step(1'b1, 1'b0, 1'b0);
      check("midrst_y_before", y_out, 0);
      step(1'b1, 1'b0, 1'b0);
      check("midrst_y_rise", y_out, 1);
      check("midrst_rise", rise_pulse, 1);
      check("midrst_gcnt", glitch_cnt, 0);

      // random runs of levels with occasional clear and reset
      lvl = 0;
      repeat (600) begin
         lvl = 1 - lvl;
         len = $urandom_range(1, 7);
         repeat (len) begin
            step(lvl[0], ($urandom_range(0, 19) == 0), ($urandom_range(0, 199) == 0));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
